// File: rtl/ws2812_frame_driver_if.sv
// Frame/handshake bundle between the LED pattern generator and the WS2812 serialiser.
// The master side supplies the frame and Start; the slave side returns the line and status.
interface ws2812_frame_driver_if #(
  parameter int NUM_LEDS = 5
);
  logic [24*NUM_LEDS-1:0] GRBSeq;
  logic                   Start;
  logic                   DOut;
  logic                   Busy;
  logic                   FrameDone;

  modport master (
    output GRBSeq, Start,
    input  DOut, Busy, FrameDone
  );

  modport slave (
    input  GRBSeq, Start,
    output DOut, Busy, FrameDone
  );
endinterface

// File: rtl/ws2812_frame_driver.sv
// Serialises a snapshotted GRB frame onto a WS2812 data line using pulse-width bit encoding,
// then holds the line low for the latch period before accepting the next frame.
module ws2812_frame_driver #(
  parameter int NUM_LEDS = 5,
  parameter int T0H      = 40,
  parameter int T1H      = 80,
  parameter int TBIT     = 125,
  parameter int TLATCH   = 6000
) (
  input  logic                 clk,
  input  logic                 reset,
  ws2812_frame_driver_if.slave bus
);

  localparam int FRAME_W = 24 * NUM_LEDS;
  localparam int MAX_CNT = (TBIT > TLATCH) ? TBIT : TLATCH;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int BIT_W   = $clog2(FRAME_W);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    LATCH
  } state_t;

  state_t               state;
  logic [FRAME_W-1:0]   shift_reg;
  logic [BIT_W-1:0]     bit_cnt;
  logic [CNT_W-1:0]     cycle_cnt;
  logic                 post_reset;
  logic                 dout;
  logic                 busy;
  logic                 frame_done;
  logic [CNT_W-1:0]     high_last;
  logic [CNT_W-1:0]     low_last;

  // Terminal counts for the bit currently at the head of the shift register.
  assign high_last = shift_reg[FRAME_W-1] ? CNT_W'(T1H - 1) : CNT_W'(T0H - 1);
  assign low_last  = shift_reg[FRAME_W-1] ? CNT_W'(TBIT - T1H - 1) : CNT_W'(TBIT - T0H - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      // A reset always passes through a full latch so a truncated frame is cleanly terminated.
      state      <= LATCH;
      cycle_cnt  <= '0;
      post_reset <= 1'b1;
      dout       <= 1'b0;
      busy       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          dout <= 1'b0;
          busy <= 1'b0;
          if (bus.Start) begin
            shift_reg <= bus.GRBSeq;
            bit_cnt   <= '0;
            cycle_cnt <= '0;
            state     <= HIGH;
            dout      <= 1'b1;
            busy      <= 1'b1;
          end
        end
        HIGH: begin
          if (cycle_cnt == high_last) begin
            cycle_cnt <= '0;
            state     <= LOW;
            dout      <= 1'b0;
          end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
        end
        LOW: begin
          if (cycle_cnt == low_last) begin
            cycle_cnt <= '0;
            if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
              state <= LATCH;
            end else begin
              shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
              bit_cnt   <= bit_cnt + BIT_W'(1);
              state     <= HIGH;
              dout      <= 1'b1;
            end
          end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
        end
        LATCH: begin
          dout <= 1'b0;
          if (cycle_cnt == CNT_W'(TLATCH - 1)) begin
            cycle_cnt  <= '0;
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= ~post_reset;
            post_reset <= 1'b0;
          end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          dout  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.DOut      = dout;
  assign bus.Busy      = busy;
  assign bus.FrameDone = frame_done;

endmodule

// File: tb/tb_ws2812_frame_driver.sv
// Directed self-checking bench for ws2812_frame_driver: decodes the serial line pulse by pulse
// and compares against hand-computed frames and cycle counts.
module tb_ws2812_frame_driver;

  localparam int NUM_LEDS = 5;
  localparam int FRAME_W  = 24 * NUM_LEDS;

  logic clk;
  logic reset;
  int   cyc;
  int   tests_run;
  int   tests_failed;

  ws2812_frame_driver_if #(.NUM_LEDS(NUM_LEDS)) bus ();

  ws2812_frame_driver #(
    .NUM_LEDS(NUM_LEDS),
    .T0H     (40),
    .T1H     (80),
    .TBIT    (125),
    .TLATCH  (6000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Results of the most recent capture_frame call.
  logic [FRAME_W-1:0] cap_bits;
  int                 cap_hi[FRAME_W];
  int                 cap_lo[FRAME_W];
  int                 cap_total;
  int                 cap_fd_cycle;
  bit                 cap_fd_seen;
  int                 cap_bad;
  int                 cap_timing_err;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts on the first high cycle of a frame and walks the line until FrameDone appears.
  task automatic capture_frame(input int change_bit, input logic [FRAME_W-1:0] change_val,
                               input bit pulse_start);
    int h;
    int l;
    bit stop;
    cap_bits       = '0;
    cap_total      = 0;
    cap_fd_seen    = 0;
    cap_fd_cycle   = 0;
    cap_bad        = 0;
    cap_timing_err = 0;
    stop           = 0;
    for (int i = 0; i < FRAME_W; i++) begin
      cap_hi[i] = 0;
      cap_lo[i] = 0;
    end
    for (int i = 0; i < FRAME_W && !stop; i++) begin
      if (i == change_bit) bus.GRBSeq = change_val;
      if (pulse_start && i == 0) bus.Start = 1'b0;
      if (pulse_start && i == 20) bus.Start = 1'b1;
      if (pulse_start && i == 21) bus.Start = 1'b0;
      if (bus.DOut !== 1'b1) begin
        cap_bad++;
        stop = 1;
      end else begin
        h = 0;
        while (bus.DOut === 1'b1 && h < 200) begin
          h++;
          step();
        end
        l = 0;
        while (bus.DOut === 1'b0 && bus.FrameDone !== 1'b1 && l < 7000) begin
          l++;
          step();
        end
        cap_hi[i] = h;
        cap_lo[i] = l;
        cap_total += h + l;
        if (h == 80) cap_bits[FRAME_W-1-i] = 1'b1;
        else if (h != 40) cap_bad++;
        if (bus.FrameDone === 1'b1) begin
          cap_fd_seen  = 1;
          cap_fd_cycle = cyc;
          if (i != FRAME_W - 1) begin
            cap_bad++;
            stop = 1;
          end
        end else if (i == FRAME_W - 1 || l >= 7000 || h >= 200) begin
          cap_bad++;
          stop = 1;
        end
      end
    end
    for (int i = 0; i < FRAME_W - 1; i++)
      if (cap_hi[i] + cap_lo[i] != 125) cap_timing_err++;
    if (cap_lo[FRAME_W-1] != 125 - cap_hi[FRAME_W-1] + 6000) cap_timing_err++;
  endtask

  task automatic test_reset();
    int busy_cnt;
    int dout_high;
    int fd_high;
    reset      = 1'b1;
    bus.Start  = 1'b0;
    bus.GRBSeq = '0;
    repeat (3) step();
    reset = 1'b0;
    tests_run++;
    if (bus.DOut !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_dout: got %b, expected 0", bus.DOut);
    end
    tests_run++;
    if (bus.Busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_busy: got %b, expected 1", bus.Busy);
    end
    tests_run++;
    if (bus.FrameDone !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_framedone: got %b, expected 0", bus.FrameDone);
    end
    busy_cnt  = 0;
    dout_high = 0;
    fd_high   = 0;
    while (bus.Busy === 1'b1 && busy_cnt < 7000) begin
      if (bus.DOut !== 1'b0) dout_high++;
      if (bus.FrameDone !== 1'b0) fd_high++;
      busy_cnt++;
      step();
    end
    tests_run++;
    if (busy_cnt != 6000) begin
      tests_failed++;
      $display("[TB] FAIL reset_latch_len: got %0d busy cycles, expected 6000", busy_cnt);
    end
    tests_run++;
    if (dout_high != 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_latch_dout: got %0d high cycles, expected 0", dout_high);
    end
    tests_run++;
    if (fd_high != 0 || bus.FrameDone !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_no_framedone: got %0d pulses (now %b), expected 0", fd_high, bus.FrameDone);
    end
  endtask

  task automatic test_reset_mid_frame();
    int busy_cnt;
    int dout_high;
    int fd_high;
    bus.GRBSeq = 120'h123456_789ABC_DEF012_345678_9ABCDE;
    bus.Start  = 1'b1;
    step();
    bus.Start = 1'b0;
    tests_run++;
    if (bus.DOut !== 1'b1 || bus.Busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL start_latency: got DOut=%b Busy=%b, expected 1 1", bus.DOut, bus.Busy);
    end
    repeat (40) step();
    tests_run++;
    if (bus.DOut !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL first_bit_t0h: got %b at cycle 41, expected 0", bus.DOut);
    end
    repeat (6250 - 40) step();
    tests_run++;
    if (bus.DOut !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bit50_start: got %b, expected 1", bus.DOut);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests_run++;
    if (bus.DOut !== 1'b0 || bus.Busy !== 1'b1 || bus.FrameDone !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_outputs: got DOut=%b Busy=%b FrameDone=%b, expected 0 1 0",
               bus.DOut, bus.Busy, bus.FrameDone);
    end
    busy_cnt  = 0;
    dout_high = 0;
    fd_high   = 0;
    while (bus.Busy === 1'b1 && busy_cnt < 7000) begin
      if (bus.DOut !== 1'b0) dout_high++;
      if (bus.FrameDone !== 1'b0) fd_high++;
      busy_cnt++;
      step();
    end
    tests_run++;
    if (busy_cnt != 6000) begin
      tests_failed++;
      $display("[TB] FAIL midreset_latch_len: got %0d busy cycles, expected 6000", busy_cnt);
    end
    tests_run++;
    if (dout_high != 0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_dout_low: got %0d high cycles, expected 0", dout_high);
    end
    tests_run++;
    if (fd_high != 0 || bus.FrameDone !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_no_framedone: got %0d pulses (now %b), expected 0", fd_high, bus.FrameDone);
    end
    // Give the design a few idle cycles to prove the aborted frame is not resumed.
    dout_high = 0;
    repeat (20) begin
      if (bus.DOut !== 1'b0 || bus.Busy !== 1'b0) dout_high++;
      step();
    end
    tests_run++;
    if (dout_high != 0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_no_resume: got %0d active cycles, expected 0", dout_high);
    end
  endtask

  task automatic test_back_to_back();
    logic [FRAME_W-1:0] frame_b;
    logic [FRAME_W-1:0] frame_c;
    int fd_a;
    int fd_b;
    int extra;
    frame_b = {24'h00FF00, 96'h0};
    frame_c = 120'hF0E1D2_C3B4A5_968778_695A4B_3C2D1E;

    bus.GRBSeq = '0;
    bus.Start  = 1'b1;
    step();
    capture_frame(-1, '0, 1'b0);
    tests_run++;
    if (cap_bad != 0 || cap_timing_err != 0) begin
      tests_failed++;
      $display("[TB] FAIL zero_frame_timing: got %0d bad bits %0d timing errs, expected 0 0", cap_bad, cap_timing_err);
    end
    tests_run++;
    if (cap_bits !== '0) begin
      tests_failed++;
      $display("[TB] FAIL zero_frame_bits: got %h, expected 0", cap_bits);
    end
    tests_run++;
    if (cap_hi[0] != 40 || cap_lo[0] != 85) begin
      tests_failed++;
      $display("[TB] FAIL zero_bit0_widths: got %0d/%0d, expected 40/85", cap_hi[0], cap_lo[0]);
    end
    tests_run++;
    if (!cap_fd_seen || cap_total != 21000) begin
      tests_failed++;
      $display("[TB] FAIL zero_frame_done_cycle: got seen=%0d at %0d, expected 1 at 21000", cap_fd_seen, cap_total);
    end
    fd_a = cap_fd_cycle;

    bus.GRBSeq = frame_b;
    step();
    tests_run++;
    if (bus.DOut !== 1'b1 || bus.FrameDone !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rise_after_done_a: got DOut=%b FrameDone=%b, expected 1 0", bus.DOut, bus.FrameDone);
    end
    capture_frame(10, {FRAME_W{1'b1}}, 1'b0);
    tests_run++;
    if (cap_bad != 0 || cap_timing_err != 0) begin
      tests_failed++;
      $display("[TB] FAIL pattern_frame_timing: got %0d bad bits %0d timing errs, expected 0 0", cap_bad, cap_timing_err);
    end
    tests_run++;
    if (cap_bits !== frame_b) begin
      tests_failed++;
      $display("[TB] FAIL snapshot_frame_bits: got %h, expected %h", cap_bits, frame_b);
    end
    tests_run++;
    if (cap_hi[8] != 80 || cap_lo[8] != 45) begin
      tests_failed++;
      $display("[TB] FAIL one_bit_widths: got %0d/%0d, expected 80/45", cap_hi[8], cap_lo[8]);
    end
    fd_b = cap_fd_seen ? cap_fd_cycle : 0;
    tests_run++;
    if (fd_b - fd_a != 21001) begin
      tests_failed++;
      $display("[TB] FAIL done_spacing_ab: got %0d, expected 21001", fd_b - fd_a);
    end

    bus.GRBSeq = frame_c;
    step();
    tests_run++;
    if (bus.DOut !== 1'b1 || bus.FrameDone !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rise_after_done_b: got DOut=%b FrameDone=%b, expected 1 0", bus.DOut, bus.FrameDone);
    end
    capture_frame(-1, '0, 1'b1);
    tests_run++;
    if (cap_bad != 0 || cap_timing_err != 0) begin
      tests_failed++;
      $display("[TB] FAIL third_frame_timing: got %0d bad bits %0d timing errs, expected 0 0", cap_bad, cap_timing_err);
    end
    tests_run++;
    if (cap_bits !== frame_c) begin
      tests_failed++;
      $display("[TB] FAIL third_frame_bits: got %h, expected %h", cap_bits, frame_c);
    end
    tests_run++;
    if (!cap_fd_seen || cap_fd_cycle - fd_b != 21001) begin
      tests_failed++;
      $display("[TB] FAIL done_spacing_bc: got %0d, expected 21001", cap_fd_cycle - fd_b);
    end

    step();
    tests_run++;
    if (bus.FrameDone !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL framedone_one_cycle: got %b, expected 0", bus.FrameDone);
    end
    extra = 0;
    repeat (300) begin
      if (bus.Busy !== 1'b0 || bus.DOut !== 1'b0) extra++;
      step();
    end
    tests_run++;
    if (extra != 0) begin
      tests_failed++;
      $display("[TB] FAIL no_extra_frame: got %0d active cycles, expected 0", extra);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    bus.Start    = 1'b0;
    bus.GRBSeq   = '0;
    test_reset();
    test_reset_mid_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
